// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared widths, iteration count and FSM state type for seq_divider
package seq_divider_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int ITER      = 8;

    // Shift/trial states interleave so that every step advances the encoding by one.
    typedef enum logic [4:0] {
        IDLE, LOAD,
        S1, T1, S2, T2, S3, T3, S4, T4,
        S5, T5, S6, T6, S7, T7, S8, T8,
        DONE
    } state_t;

    function automatic logic is_shift_state(input state_t s);
        logic [4:0] v;
        v = s;
        return (s >= S1) && (s <= S8) && !v[0];
    endfunction

    function automatic logic is_trial_state(input state_t s);
        logic [4:0] v;
        v = s;
        return (s >= T1) && (s <= T8) && v[0];
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result signal bundle for seq_divider
interface seq_divider_if;
    import seq_divider_pkg::*;

    logic                 Run;
    logic                 Load_Divisor;
    logic [DIV_WIDTH-1:0] Din;
    logic [DIV_WIDTH-1:0] Quotient;
    logic [DIV_WIDTH-1:0] Remainder;
    logic                 Done;
    logic                 DivByZero;

    modport master (
        output Run, Load_Divisor, Din,
        input  Quotient, Remainder, Done, DivByZero
    );

    modport slave (
        input  Run, Load_Divisor, Din,
        output Quotient, Remainder, Done, DivByZero
    );

endinterface

// File: rtl/seq_divider_control.sv
// rtl/seq_divider_control.sv - sequencing FSM for the restoring divider (uses DIV_ZERO_DETECT_EN)
module divider_control
    import seq_divider_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic D_is_zero,
    output logic Ld_Q,
    output logic Clr_R,
    output logic Shift,
    output logic Trial,
    output logic Done_st,
    output logic Idle_st
);

    state_t state, state_next;

`ifndef DIV_ZERO_DETECT_EN
    logic unused_d_is_zero;
    assign unused_d_is_zero = D_is_zero;
`endif

    // State register with synchronous reset to IDLE.
    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: shift/trial steps walk the encoding, DONE waits for Run to drop.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Run) state_next = LOAD;
`ifdef DIV_ZERO_DETECT_EN
            LOAD: state_next = D_is_zero ? T8 : S1;
`else
            LOAD: state_next = S1;
`endif
            DONE: if (!Run) state_next = IDLE;
            default: state_next = state_t'(state + 5'd1);
        endcase
    end

    // Datapath strobes decoded from the current state.
    always_comb begin
        Ld_Q    = (state == LOAD);
        Clr_R   = (state == LOAD);
        Shift   = is_shift_state(state);
        Trial   = is_trial_state(state);
        Done_st = (state == DONE);
        Idle_st = (state == IDLE);
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 8-bit sequential restoring divider top (optional DIV_ZERO_DETECT_EN)
module seq_divider
    import seq_divider_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    seq_divider_if.slave  bus
);

    logic [DIV_WIDTH-1:0] d_reg;
    logic [DIV_WIDTH-1:0] q_reg;
    logic [DIV_WIDTH-1:0] r_reg;
    logic                 carry;
    logic                 ld_q, clr_r, shift, trial, done_st, idle_st;
    logic                 d_is_zero;
    logic                 fits;
    logic [DIV_WIDTH-1:0] r_sub;

    assign d_is_zero = (d_reg == '0);
    // The carry out of the shift is the 9th compare bit; the difference then fits in 8 bits.
    assign fits      = ({carry, r_reg} >= {1'b0, d_reg});
    assign r_sub     = r_reg - d_reg;

    divider_control u_ctrl (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (bus.Run),
        .D_is_zero (d_is_zero),
        .Ld_Q      (ld_q),
        .Clr_R     (clr_r),
        .Shift     (shift),
        .Trial     (trial),
        .Done_st   (done_st),
        .Idle_st   (idle_st)
    );

    // Divisor, quotient, remainder and carry registers driven by the control strobes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            d_reg <= '0;
            q_reg <= '0;
            r_reg <= '0;
            carry <= 1'b0;
        end else begin
            if (idle_st && bus.Load_Divisor)
                d_reg <= bus.Din;
            if (ld_q) begin
                q_reg <= bus.Din;
                carry <= 1'b0;
            end
            if (clr_r)
                r_reg <= '0;
`ifdef DIV_ZERO_DETECT_EN
            // Zero divisor short-cuts to the result the full sequence would reach.
            if (ld_q && d_is_zero) begin
                q_reg <= '1;
                r_reg <= bus.Din;
            end
`endif
            if (shift)
                {carry, r_reg, q_reg} <= {r_reg, q_reg, 1'b0};
            if (trial) begin
                carry <= 1'b0;
                if (fits) begin
                    r_reg    <= r_sub;
                    q_reg[0] <= 1'b1;
                end
            end
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dbz_reg;

    // Divide-by-zero flag captured alongside the dividend.
    always_ff @(posedge Clk) begin
        if (Reset)
            dbz_reg <= 1'b0;
        else if (ld_q)
            dbz_reg <= d_is_zero;
    end

    assign bus.DivByZero = dbz_reg;
`else
    assign bus.DivByZero = 1'b0;
`endif

    assign bus.Quotient  = q_reg;
    assign bus.Remainder = r_reg;
    assign bus.Done      = done_st;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have port: Clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: Run  input  1  start request, level-sampled in IDLE.
REQ-004 SHALL have port: Load_Divisor  input  1  capture Din into divisor register while IDLE.
REQ-005 SHALL have port: Din  input  8  unsigned divisor (Load_Divisor) or dividend (Run).
REQ-006 SHALL have port: Quotient  output  8  registered unsigned quotient.
REQ-007 SHALL have port: Remainder  output  8  registered unsigned remainder.
REQ-008 SHALL have port: Done  output  1  result valid; high only in DONE state.
REQ-009 SHALL have port: DivByZero  output  1  divisor was zero for the current result.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, S1..S8 (shift), T1..T8 (trial-subtract), DONE.
REQ-011 IDLE: Run=1 -> LOAD; else stay; Load_Divisor=1 loads Din into divisor reg D.
REQ-012 LOAD: Q <- Din (dividend), R <- 0, Done <- 0, DivByZero <- (D==0); next S1.
REQ-013 Sk: {R,Q} shifted left 1 as one 16-bit value, Q[0] <- 0; next Tk.
REQ-014 Tk: 9-bit compare of {carry,R} against D; if >= D then R <- R-D, Q[0] <- 1, else R and Q unchanged; next S(k+1), T8 -> DONE.
REQ-015 Carry bit shifted out of R during Sk SHALL be kept as the 9th compare bit, so no overflow is possible for any D.
REQ-016 Latency: Run sampled high at edge 0 -> Done=1 after edge 17; Quotient/Remainder are final when Done rises.
REQ-017 DONE: outputs held; stay while Run=1; Run=0 -> IDLE (one result per Run pulse, no retrigger while Run is held).
REQ-018 Run and Load_Divisor SHALL be ignored in every state except IDLE (Run also in DONE per REQ-017).
REQ-019 Quotient/Remainder SHALL hold the last result in IDLE until the next LOAD.
REQ-020 Arithmetic unsigned only; Din=0 dividend yields Q=0, R=0.

Reset
REQ-021 Reset=1 at any edge, including mid-computation, SHALL force IDLE and clear D, Q, R, Done and DivByZero to 0 at that edge.
REQ-022 Reset SHALL take priority over Run and Load_Divisor in the same cycle.

Configuration
REQ-023 Macro DIV_ZERO_DETECT_EN, when defined: LOAD with D==0 SHALL go directly to DONE with Quotient=8'hFF, Remainder=dividend and DivByZero=1 (Done after edge 2).
REQ-024 DIV_ZERO_DETECT_EN undefined: DivByZero SHALL be tied 0; D==0 runs the full 17-cycle sequence and naturally yields Q=8'hFF, R=dividend.

Structure
REQ-025 Package seq_divider_pkg SHALL hold the state enum type and the DIV_WIDTH=8 and ITER=8 constants.
REQ-026 FSM SHALL be a sub-module divider_control (Clk, Reset, Run, D_is_zero -> Ld_Q, Clr_R, Shift, Trial, Done_st); the datapath stays in seq_divider.

Verification
REQ-027 Load_Divisor with D=7, Run with Din=200 -> after edge 17: Done=1, Quotient=28, Remainder=4, DivByZero=0.
REQ-028 D=1, dividend 255 -> Quotient=255, Remainder=0; D=9, dividend 5 -> Quotient=0, Remainder=5.
REQ-029 D=0, dividend 100 -> Quotient=8'hFF, Remainder=100; with macro DivByZero=1 and Done after edge 2; without macro DivByZero=0 and Done after edge 17.
REQ-030 Run held high for 40 cycles -> exactly one computation, Done stays 1; Run low -> IDLE on the next edge; Run high again -> new result.
REQ-031 Reset asserted at edge 9 of a computation -> all outputs 0 and IDLE on the next edge; a subsequent Run with D reloaded computes correctly.
REQ-032 Load_Divisor pulsed during S4 with Din=3 -> ignored; result uses the original D.
